// File: rtl/speck32_round_sequencer_if.sv
// Block-level handshake bundle for the SPECK32/64 round sequencer.
// The master side is the plaintext/key source plus ciphertext consumer;
// the slave side is the sequencer itself.
interface speck32_round_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] key;
    logic [31:0] pt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ct;
    logic        busy;
    logic [4:0]  round_idx;

    modport master (
        output in_valid, key, pt, out_ready,
        input  in_ready, out_valid, ct, busy, round_idx
    );

    modport slave (
        input  in_valid, key, pt, out_ready,
        output in_ready, out_valid, ct, busy, round_idx
    );
endinterface

// File: rtl/speck32_round_sequencer.sv
// Iterative SPECK32/64 encryption controller.
// One 16-bit round datapath (rotate, modular add, XOR) is reused once per
// cycle for ROUNDS cycles; the key schedule advances in the same cycle, so
// no round-key storage is needed beyond the k/l0/l1/l2 words.

// Shared 16-bit XOR word unit; every XOR in the datapath is an instance.
module speck32_xor_word (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module speck32_round_sequencer #(
    parameter int unsigned ROUNDS = 32'd22,  // 1..31
    parameter int unsigned ALPHA  = 32'd7,   // right rotate on x and l words
    parameter int unsigned BETA   = 32'd2    // left rotate on y and k
) (
    input  logic                          clk,
    input  logic                          rst_n,
    speck32_round_sequencer_if.slave      sif
);

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Rotate right by amt (mod 16); amt is a parameter at every call site.
    function automatic logic [15:0] ror16(input logic [15:0] w, input int unsigned amt);
        logic [15:0] r;
        r = w;
        for (int unsigned n = 32'd0; n < (amt % 32'd16); n++) begin
            r = {r[0], r[15:1]};
        end
        return r;
    endfunction

    // Rotate left by amt (mod 16).
    function automatic logic [15:0] rol16(input logic [15:0] w, input int unsigned amt);
        logic [15:0] r;
        r = w;
        for (int unsigned n = 32'd0; n < (amt % 32'd16); n++) begin
            r = {r[14:0], r[15]};
        end
        return r;
    endfunction

    state_t      r_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_k;
    logic [15:0] r_l0;
    logic [15:0] r_l1;
    logic [15:0] r_l2;
    logic [4:0]  r_idx;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;
    logic [31:0] r_ct;

    logic [15:0] w_x_sum;
    logic [15:0] w_x_next;
    logic [15:0] w_y_rot;
    logic [15:0] w_y_next;
    logic [15:0] w_l_sum;
    logic [15:0] w_idx_word;
    logic [15:0] w_l_new;
    logic [15:0] w_k_rot;
    logic [15:0] w_k_next;

    // Round function on the data words.
    assign w_x_sum = ror16(r_x, ALPHA) + r_y;
    assign w_y_rot = rol16(r_y, BETA);

    speck32_xor_word u_xor_x (.i_a(w_x_sum), .i_b(r_k),      .o_y(w_x_next));
    speck32_xor_word u_xor_y (.i_a(w_y_rot), .i_b(w_x_next), .o_y(w_y_next));

    // Same round function applied to the key words, with the round index as
    // the "round key"; lnew feeds the next k and shifts into the l pipeline.
    assign w_l_sum    = ror16(r_l0, ALPHA) + r_k;
    assign w_idx_word = {11'd0, r_idx};
    assign w_k_rot    = rol16(r_k, BETA);

    speck32_xor_word u_xor_l (.i_a(w_l_sum), .i_b(w_idx_word), .o_y(w_l_new));
    speck32_xor_word u_xor_k (.i_a(w_k_rot), .i_b(w_l_new),    .o_y(w_k_next));

    assign sif.in_ready  = r_in_ready;
    assign sif.out_valid = r_out_valid;
    assign sif.busy      = r_busy;
    assign sif.round_idx = r_idx;
    assign sif.ct        = r_ct;

    // Control FSM, round datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x         <= 16'd0;
            r_y         <= 16'd0;
            r_k         <= 16'd0;
            r_l0        <= 16'd0;
            r_l1        <= 16'd0;
            r_l2        <= 16'd0;
            r_idx       <= 5'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ct        <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sif.in_valid && r_in_ready) begin
                        r_x        <= sif.pt[31:16];
                        r_y        <= sif.pt[15:0];
                        r_k        <= sif.key[15:0];
                        r_l0       <= sif.key[31:16];
                        r_l1       <= sif.key[47:32];
                        r_l2       <= sif.key[63:48];
                        r_idx      <= 5'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_x  <= w_x_next;
                    r_y  <= w_y_next;
                    r_k  <= w_k_next;
                    r_l0 <= r_l1;
                    r_l1 <= r_l2;
                    r_l2 <= w_l_new;
                    if (r_idx == LAST_IDX) begin
                        // Capture the final round result directly into ct.
                        r_ct        <= {w_x_next, w_y_next};
                        r_idx       <= 5'd0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (sif.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    r_state     <= ST_IDLE;
                    r_idx       <= 5'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speck32_round_sequencer.sv
// Self-checking bench for speck32_round_sequencer: table of block vectors
// (known answer, held output, input noise, all-zero, random) plus hand-written
// back-to-back and mid-run reset sequences, checked against a reference model.
module tb_speck32_round_sequencer;

    localparam int ROUNDS = 22;
    localparam logic [63:0] T1_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] T1_PT  = 32'h6574_694c;
    localparam logic [31:0] T1_CT  = 32'ha868_42f2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    speck32_round_sequencer_if sif ();

    speck32_round_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic [31:0] pt;
        logic [31:0] ct;
        int          hold;
        bit          noise;
    } vec_t;

    function automatic logic [15:0] ror(input logic [15:0] v, input int a);
        return (v >> a) | (v << (16 - a));
    endfunction

    function automatic logic [15:0] rol(input logic [15:0] v, input int a);
        return (v << a) | (v >> (16 - a));
    endfunction

    // Reference SPECK32/64: expand the full round-key list first, then encrypt.
    function automatic logic [31:0] speck_ref(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] l  [0:ROUNDS+1];
        logic [15:0] rk [0:ROUNDS-1];
        logic [15:0] x;
        logic [15:0] y;
        rk[0] = key[15:0];
        l[0]  = key[31:16];
        l[1]  = key[47:32];
        l[2]  = key[63:48];
        for (int i = 0; i < ROUNDS - 1; i++) begin
            l[i+3]  = (ror(l[i], 7) + rk[i]) ^ 16'(i);
            rk[i+1] = rol(rk[i], 2) ^ l[i+3];
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            x = (ror(x, 7) + y) ^ rk[i];
            y = rol(y, 2) ^ x;
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push one block through: accept, per-round checks, latency, ct, optional hold.
    task automatic run_block(input vec_t v);
        int  edges;
        int  guard;
        bit  seen;
        guard = 0;
        while (!sif.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_accept", {63'd0, sif.in_ready}, 64'd1);
        sif.out_ready = (v.hold == 0);
        sif.key       = v.key;
        sif.pt        = v.pt;
        sif.in_valid  = 1'b1;
        @(posedge clk);
        edges = 1;
        seen  = 1'b0;
        while (edges < 40) begin
            @(negedge clk);
            if (sif.out_valid) begin
                seen = 1'b1;
                sif.in_valid = 1'b0;
                break;
            end
            check("round_idx", 64'(sif.round_idx), 64'(edges - 1));
            check("busy_in_run", {63'd0, sif.busy}, 64'd1);
            check("in_ready_in_run", {63'd0, sif.in_ready}, 64'd0);
            if (v.noise) begin
                sif.in_valid = 1'($urandom_range(1, 0));
                sif.key      = {$urandom, $urandom};
                sif.pt       = $urandom;
            end else begin
                sif.in_valid = 1'b0;
            end
            @(posedge clk);
            edges++;
        end
        check("out_valid_seen", {63'd0, seen}, 64'd1);
        check("latency_edges", 64'(edges), 64'(ROUNDS + 1));
        check("ct", 64'(sif.ct), 64'(v.ct));
        check("round_idx_done", 64'(sif.round_idx), 64'd0);
        check("busy_done", {63'd0, sif.busy}, 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("ct_held", 64'(sif.ct), 64'(v.ct));
            check("out_valid_held", {63'd0, sif.out_valid}, 64'd1);
            check("in_ready_held", {63'd0, sif.in_ready}, 64'd0);
        end
        sif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_after_hs", {63'd0, sif.out_valid}, 64'd0);
        check("in_ready_after_hs", {63'd0, sif.in_ready}, 64'd1);
        check("ct_kept_after_hs", 64'(sif.ct), 64'(v.ct));
    endtask

    vec_t        vecs [6];
    logic [63:0] bk [4];
    logic [31:0] bp [4];
    int          acc_t [4];
    logic [31:0] q_exp [$];
    logic [31:0] exp_v;
    int          acc;
    int          got;
    int          cyc;
    int          guard;

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        sif.key       = 64'd0;
        sif.pt        = 32'd0;

        vecs[0] = '{key: T1_KEY, pt: T1_PT, ct: T1_CT, hold: 0,  noise: 1'b0};
        vecs[1] = '{key: T1_KEY, pt: T1_PT, ct: T1_CT, hold: 10, noise: 1'b0};
        vecs[2] = '{key: T1_KEY, pt: T1_PT, ct: T1_CT, hold: 0,  noise: 1'b1};
        vecs[3] = '{key: 64'd0,  pt: 32'd0, ct: speck_ref(64'd0, 32'd0), hold: 0, noise: 1'b0};
        for (int i = 4; i < 6; i++) begin
            vecs[i].key   = {$urandom, $urandom};
            vecs[i].pt    = $urandom;
            vecs[i].ct    = speck_ref(vecs[i].key, vecs[i].pt);
            vecs[i].hold  = i - 3;
            vecs[i].noise = 1'b1;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, sif.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, sif.out_valid}, 64'd0);
        check("rst_busy", {63'd0, sif.busy}, 64'd0);
        check("rst_round_idx", 64'(sif.round_idx), 64'd0);
        check("rst_ct", 64'(sif.ct), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i]);
        end

        // Back-to-back: in_valid held high, out_ready high
        bk[0] = T1_KEY;
        bp[0] = T1_PT;
        for (int i = 1; i < 4; i++) begin
            bk[i] = {$urandom, $urandom};
            bp[i] = $urandom;
        end
        sif.out_ready = 1'b1;
        acc = 0;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sif.out_valid) begin
                exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 32'hdead_beef;
                check("b2b_ct", 64'(sif.ct), 64'(exp_v));
                got++;
            end
            if (acc < 4) begin
                sif.key      = bk[acc];
                sif.pt       = bp[acc];
                sif.in_valid = 1'b1;
                if (sif.in_ready) begin
                    acc_t[acc] = cyc;
                    q_exp.push_back(speck_ref(bk[acc], bp[acc]));
                    acc++;
                end
            end else begin
                sif.in_valid = 1'b0;
            end
        end
        sif.in_valid = 1'b0;
        check("b2b_accepted", 64'(acc), 64'd4);
        check("b2b_outputs", 64'(got), 64'd4);
        for (int i = 1; i < 4; i++) begin
            check("b2b_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'(ROUNDS + 2));
        end

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        sif.key      = T1_KEY;
        sif.pt       = T1_PT;
        sif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
        guard = 0;
        while (sif.round_idx != 5'd11 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("abort_at_round11", 64'(sif.round_idx), 64'd11);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, sif.out_valid}, 64'd0);
        check("abort_busy", {63'd0, sif.busy}, 64'd0);
        check("abort_in_ready", {63'd0, sif.in_ready}, 64'd1);
        check("abort_round_idx", 64'(sif.round_idx), 64'd0);
        check("abort_ct", 64'(sif.ct), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
